// File: rtl/pipe_add_sub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES slices, one per stage,
// with skewed operand slices and aligned result slices, and a single global valid/ready stall.
module pipe_add_sub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int unsigned SW = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
        $error("pipe_add_sub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // Stage-k inputs: index 0 comes from the ports, index k+1 from stage k's registers.
    logic             w_v   [STAGES];
    logic             w_c   [STAGES];
    logic [WIDTH-1:0] w_a   [STAGES];
    logic [WIDTH-1:0] w_b   [STAGES];
    logic [WIDTH-1:0] w_sum [STAGES];

    logic             r_o_valid;
    logic [WIDTH-1:0] r_o_sum;
    logic             r_o_carry;
    logic             r_o_overflow;

    logic             w_adv;

    // The whole pipeline advances together; a held output freezes every stage.
    assign o_ready = i_ready || !r_o_valid;
    assign w_adv   = o_ready;

    // Subtract is folded in at acceptance so later stages only ever add.
    assign w_v[0]   = i_valid;
    assign w_a[0]   = i_a;
    assign w_b[0]   = i_b ^ {WIDTH{i_sub}};
    assign w_c[0]   = i_cin ^ i_sub;
    assign w_sum[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW:0]      w_slice;
        logic [WIDTH-1:0] w_sum_nxt;

        // Slice k of the carry chain; lower result slices pass through unchanged.
        always_comb begin
            w_slice   = {1'b0, w_a[k][k*SW +: SW]} + {1'b0, w_b[k][k*SW +: SW]} + (SW+1)'(w_c[k]);
            w_sum_nxt = w_sum[k];
            w_sum_nxt[k*SW +: SW] = w_slice[SW-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] w_a_nxt;
            logic [WIDTH-1:0] w_b_nxt;
            logic             r_v;
            logic             r_c;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_sum;

            // Only the not-yet-consumed operand slices are skewed forward.
            always_comb begin
                w_a_nxt = '0;
                w_b_nxt = '0;
                for (int unsigned s = k + 1; s < STAGES; s++) begin
                    w_a_nxt[s*SW +: SW] = w_a[k][s*SW +: SW];
                    w_b_nxt[s*SW +: SW] = w_b[k][s*SW +: SW];
                end
            end

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_v   <= 1'b0;
                    r_c   <= 1'b0;
                    r_a   <= '0;
                    r_b   <= '0;
                    r_sum <= '0;
                end else if (w_adv) begin
                    r_v   <= w_v[k];
                    r_c   <= w_slice[SW];
                    r_a   <= w_a_nxt;
                    r_b   <= w_b_nxt;
                    r_sum <= w_sum_nxt;
                end
            end

            assign w_v[k+1]   = r_v;
            assign w_c[k+1]   = r_c;
            assign w_a[k+1]   = r_a;
            assign w_b[k+1]   = r_b;
            assign w_sum[k+1] = r_sum;
        end else begin : g_last
            // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ sum.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_o_valid    <= 1'b0;
                    r_o_sum      <= '0;
                    r_o_carry    <= 1'b0;
                    r_o_overflow <= 1'b0;
                end else if (w_adv) begin
                    r_o_valid    <= w_v[k];
                    r_o_sum      <= w_sum_nxt;
                    r_o_carry    <= w_slice[SW];
                    r_o_overflow <= w_a[k][WIDTH-1] ^ w_b[k][WIDTH-1]
                                  ^ w_sum_nxt[WIDTH-1] ^ w_slice[SW];
                end
            end
        end
    end

    assign o_valid    = r_o_valid;
    assign o_sum      = r_o_sum;
    assign o_carry    = r_o_carry;
    assign o_overflow = r_o_overflow;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Directed bench for pipe_add_sub: 16-bit/4-stage vectors and stall/bubble/reset
// sequences, plus an 8-bit single-stage instance.
module tb_pipe_add_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v, rdy_o, ird, cin, sub, o_v, o_c, o_ov;
    logic [15:0] a, b, o_s;
    logic        v8, rdy8, ird8, cin8, sub8, o_v8, o_c8, o_ov8;
    logic [7:0]  a8, b8, o_s8;

    pipe_add_sub #(.WIDTH(16), .STAGES(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v), .o_ready(rdy_o),
        .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
        .o_valid(o_v), .i_ready(ird), .o_sum(o_s), .o_carry(o_c), .o_overflow(o_ov)
    );

    pipe_add_sub #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(rdy8),
        .i_a(a8), .i_b(b8), .i_cin(cin8), .i_sub(sub8),
        .o_valid(o_v8), .i_ready(ird8), .o_sum(o_s8), .o_carry(o_c8), .o_overflow(o_ov8)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        c;
        logic        ov;
    } vec_t;

    typedef struct packed {
        logic [15:0] sum;
        logic        c;
        logic        ov;
    } res_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t q[$];

    task automatic chk_w(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mcin, input logic msub);
        logic [15:0] bb;
        logic [16:0] f;
        res_t        r;
        bb   = msub ? ~mb : mb;
        f    = 17'(ma) + 17'(bb) + 17'(mcin ^ msub);
        r.sum = f[15:0];
        r.c   = f[16];
        r.ov  = (ma[15] == bb[15]) && (f[15] != ma[15]);
        return r;
    endfunction

    task automatic chk_res(input string nm, input res_t e);
        chk_w($sformatf("%s_sum", nm), o_s, e.sum);
        chk_b($sformatf("%s_carry", nm), o_c, e.c);
        chk_b($sformatf("%s_ovf", nm), o_ov, e.ov);
    endtask

    vec_t vecs[13];

    initial begin
        int   cnt_in, cnt_out, stall_left, cyc, opn;
        logic hold;
        res_t held, e;
        logic [19:0] vhist;

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'h0010, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[9]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[10] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[11] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[12] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst_n = 1'b0; v = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; ird = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; ird8 = 1'b1;
        tick();
        tick();
        chk_b("rst_valid", o_v, 1'b0);
        chk_w("rst_sum", o_s, 16'h0000);
        chk_b("rst_carry", o_c, 1'b0);
        chk_b("rst_ovf", o_ov, 1'b0);
        chk_b("rst_ready", rdy_o, 1'b1);
        chk_b("rst_valid8", o_v8, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single operations through an empty pipe: exact 4-cycle latency.
        for (int i = 0; i < 13; i++) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub; v = 1'b1;
            #1;
            chk_b($sformatf("vec%0d_ready", i), rdy_o, 1'b1);
            tick();
            v = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = ~sub; cin = ~cin;
            tick();
            tick();
            chk_b($sformatf("vec%0d_early", i), o_v, 1'b0);
            tick();
            chk_b($sformatf("vec%0d_valid", i), o_v, 1'b1);
            chk_w($sformatf("vec%0d_sum", i), o_s, vecs[i].sum);
            chk_b($sformatf("vec%0d_carry", i), o_c, vecs[i].c);
            chk_b($sformatf("vec%0d_ovf", i), o_ov, vecs[i].ov);
            tick();
        end

        // Eight back-to-back adds with a 3-cycle downstream stall after the 2nd result.
        cnt_in = 0; cnt_out = 0; stall_left = 0; cyc = 0; hold = 1'b0; held = '0;
        while (cnt_out < 8 && cyc < 60) begin
            ird = (stall_left == 0);
            v   = (cnt_in < 8);
            a   = 16'(cnt_in + 1);
            b   = 16'(16'h0100 * (cnt_in + 1));
            cin = 1'b0; sub = 1'b0;
            #1;
            chk_b($sformatf("s36_ready_c%0d", cyc), rdy_o, ird || !o_v);
            if (hold) begin
                chk_b($sformatf("s36_hold_valid_c%0d", cyc), o_v, 1'b1);
                chk_res($sformatf("s36_hold_c%0d", cyc), held);
            end
            if (o_v && ird) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL s36_extra: got result 0x%0h expected none", o_s);
                end else begin
                    e = q.pop_front();
                    chk_res($sformatf("s36_res%0d", cnt_out), e);
                end
                cnt_out++;
                if (cnt_out == 2) stall_left = 3;
            end else if (!ird) begin
                stall_left--;
            end
            if (v && rdy_o) begin
                q.push_back(model(a, b, cin, sub));
                cnt_in++;
            end
            hold = o_v && !ird;
            held = '{o_s, o_c, o_ov};
            tick();
            cyc++;
        end
        ird = 1'b1; v = 1'b0;
        chk_w("s36_count", 16'(cnt_out), 16'd8);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk_b($sformatf("s36_drain%0d", i), o_v, 1'b0);
            tick();
        end
        q.delete();

        // Alternating bubbles with i_sub toggling per op; i_sub/i_cin scrambled in bubbles.
        opn = 0; vhist = '0;
        for (int c = 0; c < 20; c++) begin
            v   = (c < 12) && (c % 2 == 0);
            a   = 16'($urandom);
            b   = 16'($urandom);
            sub = v ? opn[0] : 1'($urandom);
            cin = 1'($urandom);
            ird = 1'b1;
            #1;
            chk_b($sformatf("s37_valid_c%0d", c), o_v, (c >= 4) ? vhist[c-4] : 1'b0);
            if (o_v) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL s37_extra: got result 0x%0h expected none", o_s);
                end else begin
                    e = q.pop_front();
                    chk_res($sformatf("s37_c%0d", c), e);
                end
            end
            if (v && rdy_o) begin
                q.push_back(model(a, b, cin, sub));
                opn++;
            end
            vhist[c] = v;
            tick();
        end
        v = 1'b0;
        chk_w("s37_left", 16'(q.size()), 16'd0);
        q.delete();

        // Reset with three operations in flight.
        for (int n = 1; n <= 3; n++) begin
            a = 16'(n * 16'h1111); b = 16'h0101; cin = 1'b0; sub = 1'b0; v = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; v = 1'b0;
        chk_b("s38_valid", o_v, 1'b0);
        chk_w("s38_sum", o_s, 16'h0000);
        chk_b("s38_carry", o_c, 1'b0);
        chk_b("s38_ovf", o_ov, 1'b0);
        chk_b("s38_ready", rdy_o, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_b($sformatf("s38_quiet%0d", i), o_v, 1'b0);
        end

        // Single-stage 8-bit instance: latency 1.
        a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b1; v8 = 1'b1;
        #1;
        chk_b("w8_early", o_v8, 1'b0);
        tick();
        chk_b("w8_sub_valid", o_v8, 1'b1);
        chk_w("w8_sub_sum", 16'(o_s8), 16'h007F);
        chk_b("w8_sub_carry", o_c8, 1'b1);
        chk_b("w8_sub_ovf", o_ov8, 1'b1);
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        chk_b("w8_add_valid", o_v8, 1'b1);
        chk_w("w8_add_sum", 16'(o_s8), 16'h0080);
        chk_b("w8_add_carry", o_c8, 1'b0);
        chk_b("w8_add_ovf", o_ov8, 1'b1);
        tick();
        chk_b("w8_bubble", o_v8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
